// File: rtl/sram_controller_if.sv
// sram_controller_if
//   CPU-side request/response bundle between the MEM stage and the SRAM
//   controller: one 32-bit read or write in flight at a time.
//   rd_en/wr_en  : level requests, held by the requester until ready
//   address      : CPU byte address
//   write_data   : store data
//   read_data    : load data (registered in the controller)
//   ready        : low while a request is in progress (pipeline freeze)
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// sram_controller
//   Performs one 32-bit CPU access as two 16-bit accesses (low half first)
//   on an external asynchronous SRAM, then idles WAIT_CYCLES cycles before
//   signalling completion.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : CPU-side request/response (slave modport)
//   SRAM_DQ    : SRAM data bus, driven only during write half-accesses
//   SRAM_ADDR  : SRAM halfword address
//   SRAM_WE_N  : SRAM write enable, active low
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N : tied active
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_controller_if.slave         bus,
    inout  wire  [15:0]              SRAM_DQ,
    output logic [17:0]              SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_LO = 3'd1,
        ACC_HI = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [17:0] r_addr;
    logic [3:0]  r_cnt;

    logic        w_req;
    logic [31:0] w_off;
    logic [16:0] w_word;
    logic        w_ready;
    logic        w_we_n;
    logic        w_drive;
    logic [15:0] w_dq_out;
    logic        w_unused;

    assign w_req  = bus.rd_en | bus.wr_en;
    // Offset wraps mod 2^32; sub-word bits and bits above the SRAM span drop.
    assign w_off  = bus.address - BASE_ADDR;
    assign w_word = w_off[18:2];
    assign w_unused = ^{w_off[31:19], w_off[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_addr  <= 18'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    // Everything the access needs is captured here, so the
                    // requester may change its inputs once accepted.
                    if (w_req) begin
                        r_wr    <= bus.wr_en;
                        r_wdata <= bus.write_data;
                        r_addr  <= {w_word, 1'b0};
                    end
                end
                ACC_LO: begin
                    if (!r_wr) r_rdata[15:0] <= SRAM_DQ;
                    r_addr[0] <= 1'b1;
                end
                ACC_HI: begin
                    if (!r_wr) r_rdata[31:16] <= SRAM_DQ;
                    r_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_we_n   = 1'b1;
        w_drive  = 1'b0;
        w_dq_out = 16'd0;
        case (r_state)
            IDLE: begin
                w_ready = ~w_req;
                if (w_req) w_next = ACC_LO;
            end
            ACC_LO: begin
                w_we_n   = ~r_wr;
                w_drive  = r_wr;
                w_dq_out = r_wdata[15:0];
                w_next   = ACC_HI;
            end
            ACC_HI: begin
                w_we_n   = ~r_wr;
                w_drive  = r_wr;
                w_dq_out = r_wdata[31:16];
                w_next   = WAIT;
            end
            WAIT: begin
                // <= 1 also covers a zero count, so the wait cannot hang.
                if (r_cnt <= 4'd1) w_next = DONE;
            end
            DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.ready     = w_ready;
    assign bus.read_data = r_rdata;
    assign SRAM_ADDR     = r_addr;
    assign SRAM_WE_N     = w_we_n;
    assign SRAM_DQ       = w_drive ? w_dq_out : 16'hzzzz;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_OE_N     = 1'b0;

endmodule
